// File: rtl/nonrestoring_divider_pkg.sv
// Shared types and constants for the unsigned non-restoring divider.
// Status flag indices are used both for the pending-exception and result status vectors.
package nonrestoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_DBZ  = 0;
  localparam int FLAG_OVF  = 1;
  localparam int NUM_FLAGS = 2;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface nonrestoring_divider_if #(
  parameter int N = 8
);
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic [N-1:0]     quotient;
  logic [N-1:0]     remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/nonrestoring_divider_step.sv
// One non-restoring iteration: shift {P,L} left, then add or subtract the divisor
// depending on the sign of the old partial remainder.
module nrd_step #(
  parameter int N = 8
) (
  input  logic [N:0]   p,
  input  logic         l_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   p_next,
  output logic         q_bit
);
  logic [N:0] p_shift;
  logic [N:0] d_ext;

  always_comb begin
    p_shift = {p[N-1:0], l_msb};
    d_ext   = {1'b0, divisor};
    p_next  = p[N] ? (p_shift + d_ext) : (p_shift - d_ext);
    q_bit   = ~p_next[N];
  end
endmodule

// File: rtl/nonrestoring_divider_param.sv
// Handshaked unsigned 2N/N non-restoring divider, one quotient bit per clock.
// Exceptions take a single busy cycle so their done arrives one cycle after acceptance.
module nonrestoring_divider_param
  import nonrestoring_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  nonrestoring_divider_if.slave    bus
);
  localparam int CNT_W = cnt_width(N);

  state_t               state_reg;
  logic [N:0]           p_reg;
  logic [N-1:0]         l_reg;
  logic [N-1:0]         q_reg;
  logic [N-1:0]         dvs_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [NUM_FLAGS-1:0] pend_reg;
  logic [NUM_FLAGS-1:0] status_reg;
  logic [N-1:0]         quotient_reg;
  logic [N-1:0]         remainder_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic [N:0]           step_p;
  logic                 step_q;
  logic [N-1:0]         q_next;
  logic [N-1:0]         p_fix;
  logic [N-1:0]         dvd_hi;
  logic [N-1:0]         dvd_lo;
  logic                 div_zero;
  logic                 div_ovf;

  nrd_step #(.N(N)) u_step (
    .p       (p_reg),
    .l_msb   (l_reg[N-1]),
    .divisor (dvs_reg),
    .p_next  (step_p),
    .q_bit   (step_q)
  );

  // The true remainder lies in [0, divisor), so the correction can be done modulo 2^N.
  always_comb begin
    q_next   = {q_reg[N-2:0], step_q};
    p_fix    = step_p[N] ? (step_p[N-1:0] + dvs_reg) : step_p[N-1:0];
    dvd_hi   = bus.dividend[2*N-1:N];
    dvd_lo   = bus.dividend[N-1:0];
    div_zero = (bus.divisor == '0);
    div_ovf  = !div_zero && (dvd_hi >= bus.divisor);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      p_reg         <= '0;
      l_reg         <= '0;
      q_reg         <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      pend_reg      <= '0;
      status_reg    <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            dvs_reg            <= bus.divisor;
            l_reg              <= dvd_lo;
            p_reg              <= {1'b0, dvd_hi};
            q_reg              <= '0;
            pend_reg[FLAG_DBZ] <= div_zero;
            pend_reg[FLAG_OVF] <= div_ovf;
            cnt_reg            <= (div_zero || div_ovf) ? CNT_W'(1) : CNT_W'(N);
            busy_reg           <= 1'b1;
            state_reg          <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (|pend_reg) begin
            // l_reg still holds the untouched low dividend half for divide-by-zero.
            quotient_reg  <= '1;
            remainder_reg <= pend_reg[FLAG_DBZ] ? l_reg : '0;
            status_reg    <= pend_reg;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            p_reg <= step_p;
            l_reg <= {l_reg[N-2:0], 1'b0};
            q_reg <= q_next;
            if (cnt_reg == CNT_W'(1)) begin
              quotient_reg  <= q_next;
              remainder_reg <= p_fix;
              status_reg    <= '0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = status_reg[FLAG_DBZ];
  assign bus.overflow    = status_reg[FLAG_OVF];
endmodule

// File: tb/tb_nonrestoring_divider_param.sv
// Scoreboard bench for the divider: drivers push expected results, per-instance
// monitors pop and compare on every done pulse (values, flags and latency).
module tb_nonrestoring_divider_param;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8;
  exp_t e16;

  nonrestoring_divider_if #(.N(8))  b8();
  nonrestoring_divider_if #(.N(16)) b16();

  nonrestoring_divider_param #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  nonrestoring_divider_param #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the N=8 instance
  always @(negedge clk) begin
    if (!rst && b8.done) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL n8_spurious_done: done with no outstanding operation (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        $display("n8  txn: q=%0d r=%0d dbz=%0b ovf=%0b at cycle %0d", b8.quotient, b8.remainder,
                 b8.div_by_zero, b8.overflow, cyc);
        cmp("n8_quotient", {24'h0, b8.quotient}, {16'h0, e8.q});
        cmp("n8_remainder", {24'h0, b8.remainder}, {16'h0, e8.r});
        cmp("n8_div_by_zero", {31'h0, b8.div_by_zero}, {31'h0, e8.dbz});
        cmp("n8_overflow", {31'h0, b8.overflow}, {31'h0, e8.ovf});
        cmp("n8_latency", cyc, e8.due);
        cmp("n8_busy_with_done", {31'h0, b8.busy}, 32'h0);
      end
    end
  end

  // Monitor for the N=16 instance
  always @(negedge clk) begin
    if (!rst && b16.done) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL n16_spurious_done: done with no outstanding operation (cycle %0d)", cyc);
      end else begin
        e16 = q16.pop_front();
        $display("n16 txn: q=%0d r=%0d dbz=%0b ovf=%0b at cycle %0d", b16.quotient, b16.remainder,
                 b16.div_by_zero, b16.overflow, cyc);
        cmp("n16_quotient", {16'h0, b16.quotient}, {16'h0, e16.q});
        cmp("n16_remainder", {16'h0, b16.remainder}, {16'h0, e16.r});
        cmp("n16_flags", {30'h0, b16.div_by_zero, b16.overflow}, {30'h0, e16.dbz, e16.ovf});
        cmp("n16_latency", cyc, e16.due);
        cmp("n16_busy_with_done", {31'h0, b16.busy}, 32'h0);
      end
    end
  end

  // Leaves start high after the accepting edge; the caller decides when to drop it.
  task automatic issue8(input logic [15:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                        input logic [7:0] er, input logic edz, input logic eov, input int lat);
    exp_t e;
    @(negedge clk);
    b8.start    = 1'b1;
    b8.dividend = dd;
    b8.divisor  = dv;
    @(posedge clk);
    #1;
    e.q = {8'h00, eq};
    e.r = {8'h00, er};
    e.dbz = edz;
    e.ovf = eov;
    e.due = cyc + lat;
    q8.push_back(e);
  endtask

  task automatic wait_done8(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: done=0 after 40 cycles, expected done=1", nm);
    end
  endtask

  task automatic op8(input logic [15:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                     input logic [7:0] er, input logic edz, input logic eov, input int lat);
    issue8(dd, dv, eq, er, edz, eov, lat);
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8("n8_op");
  endtask

  task automatic op16(input logic [31:0] dd, input logic [15:0] dv, input logic [15:0] eq,
                      input logic [15:0] er);
    exp_t e;
    bit   seen;
    @(negedge clk);
    b16.start    = 1'b1;
    b16.dividend = dd;
    b16.divisor  = dv;
    @(posedge clk);
    #1;
    e.q = eq;
    e.r = er;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.due = cyc + 16;
    q16.push_back(e);
    @(negedge clk);
    b16.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b16.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL n16_op_timeout: done=0 after 60 cycles, expected done=1");
    end
  endtask

  task automatic check_zero8(input string tag);
    cmp({tag, "_quotient"}, {24'h0, b8.quotient}, 32'h0);
    cmp({tag, "_remainder"}, {24'h0, b8.remainder}, 32'h0);
    cmp({tag, "_busy_done"}, {30'h0, b8.busy, b8.done}, 32'h0);
    cmp({tag, "_flags"}, {30'h0, b8.div_by_zero, b8.overflow}, 32'h0);
  endtask

  // N=16 vectors chosen as (q, d, r) with r < d; dividend = q*d + r
  int unsigned tq[6] = '{12345, 65535, 1, 40000, 0, 777};
  int unsigned td[6] = '{678, 65535, 1, 3, 500, 40000};
  int unsigned tr[6] = '{123, 65534, 0, 2, 499, 39999};

  initial begin
    bit seen;
    longint unsigned dd;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    b8.start = 1'b0;
    b8.dividend = '0;
    b8.divisor = '0;
    b16.start = 1'b0;
    b16.dividend = '0;
    b16.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero8("n8_reset");
    cmp("n16_reset_outputs", {b16.quotient, b16.remainder}, 32'h0);
    cmp("n16_reset_status", {28'h0, b16.busy, b16.done, b16.div_by_zero, b16.overflow}, 32'h0);
    rst = 1'b0;

    op8(16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);
    op8(16'hFE01, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0, 8);
    op8(16'h00FF, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 8);
    op8(16'h1234, 8'd0, 8'hFF, 8'h34, 1'b1, 1'b0, 1);
    op8(16'h0A00, 8'h0A, 8'hFF, 8'h00, 1'b0, 1'b1, 1);

    // Back-to-back: start stays high; junk operands while busy must be ignored
    issue8(16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);
    @(negedge clk);
    b8.dividend = 16'hFFFF;
    b8.divisor  = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL n8_b2b_first_timeout: done=0 after 40 cycles, expected done=1");
    end
    b8.dividend = 16'd200;
    b8.divisor  = 8'd9;
    @(posedge clk);
    #1;
    q8.push_back('{q: 16'd22, r: 16'd2, dbz: 1'b0, ovf: 1'b0, due: cyc + 8});
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8("n8_b2b_second");

    // Reset in the 4th RUN cycle: operation discarded, no done afterwards
    @(negedge clk);
    b8.start    = 1'b1;
    b8.dividend = 16'd100;
    b8.divisor  = 8'd7;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero8("n8_midreset");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    op8(16'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 8);

    for (int k = 0; k < 6; k++) begin
      dd = longint'(tq[k]) * longint'(td[k]) + longint'(tr[k]);
      op16(dd[31:0], td[k][15:0], tq[k][15:0], tr[k][15:0]);
    end

    repeat (3) @(negedge clk);
    cmp("outstanding_results", q8.size() + q16.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected to have finished");
    $fatal(1, "global timeout");
  end

endmodule
